// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch-stage types and constants
package core_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} fetch_state_e;

  typedef enum logic [1:0] {NONE, TRAP, MRET, BRANCH} redirect_src_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            err;
  } fetch_buf_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction memory port and IF/ID buffer handshake
interface fetch_ctrl_if;
  import core_pkg::*;

  logic            imem_req_valid_o;
  logic            imem_req_ready_i;
  logic [XLEN-1:0] imem_req_addr_o;
  logic            imem_rsp_valid_i;
  logic [ILEN-1:0] imem_rsp_data_i;
  logic            imem_rsp_err_i;
  logic            if_valid_o;
  logic            if_ready_i;
  logic [XLEN-1:0] if_pc_o;
  logic [ILEN-1:0] if_instr_o;
  logic            if_err_o;

  modport master (
    output imem_req_valid_o, imem_req_addr_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
    output if_valid_o, if_pc_o, if_instr_o, if_err_o,
    input  if_ready_i
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
    input  if_valid_o, if_pc_o, if_instr_o, if_err_o,
    output if_ready_i
  );

endinterface

// File: rtl/pc_redirect_sel.sv
// rtl/pc_redirect_sel.sv - priority select of PC redirect: trap > mret > branch
module pc_redirect_sel
  import core_pkg::*;
(
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            mret,
  input  logic [XLEN-1:0] mepc,
  input  logic            branch,
  input  logic [XLEN-1:0] branch_target,
  output logic            redirect,
  output logic [XLEN-1:0] target,
  output redirect_src_e   src
);

  assign redirect = trap | mret | branch;

  always_comb begin
    src    = NONE;
    target = '0;
    if (trap) begin
      src    = TRAP;
      target = word_align(trap_vector);
    end else if (mret) begin
      src    = MRET;
      target = word_align(mepc);
    end else if (branch) begin
      src    = BRANCH;
      target = word_align(branch_target);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC owner and single-outstanding instruction fetch sequencer
module fetch_ctrl
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  fetch_ctrl_if.master    bus,
  input  logic            stall_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vector_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            flush_o
);

  localparam logic [1:0] ST_BOOT = S_BOOT;
  localparam logic [1:0] ST_REQ  = S_REQ;
  localparam logic [1:0] ST_WAIT = S_WAIT;
  localparam logic [1:0] ST_HOLD = S_HOLD;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, req_addr_q, target;
  logic            discard_q, redirect, req_fire, if_fire;
  redirect_src_e   redirect_src;
  fetch_buf_t      buf_q;

  pc_redirect_sel u_redirect_sel (
    .trap          (trap_i),
    .trap_vector   (trap_vector_i),
    .mret          (mret_i),
    .mepc          (mepc_i),
    .branch        (branch_taken_i),
    .branch_target (branch_target_i),
    .redirect      (redirect),
    .target        (target),
    .src           (redirect_src)
  );

  assign req_fire = (state_q == ST_REQ) && bus.imem_req_ready_i;
  assign if_fire  = (state_q == ST_HOLD) && bus.if_ready_i && !stall_i && !redirect;

  // Once a redirect has marked the pending fetch stale, pc_q already holds the target.
  always_comb begin
    pc_d = pc_q;
    if (redirect_src != NONE) begin
      pc_d = target;
    end else if (req_fire && !discard_q) begin
      pc_d = req_addr_q + 32'd4;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ:  if (bus.imem_req_ready_i) state_d = ST_WAIT;
      ST_WAIT: if (bus.imem_rsp_valid_i) state_d = (discard_q || redirect) ? ST_REQ : ST_HOLD;
      ST_HOLD: if (redirect || if_fire) state_d = ST_REQ;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_BOOT;
      pc_q       <= BOOT_ADDR;
      req_addr_q <= BOOT_ADDR;
      discard_q  <= 1'b0;
      buf_q      <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_d == ST_REQ && state_q != ST_REQ) begin
        req_addr_q <= pc_d;
      end
      if (state_q == ST_REQ && redirect) begin
        discard_q <= 1'b1;
      end else if (state_q == ST_WAIT) begin
        if (bus.imem_rsp_valid_i) begin
          discard_q <= 1'b0;
        end else if (redirect) begin
          discard_q <= 1'b1;
        end
      end
      if (state_q == ST_WAIT && state_d == ST_HOLD) begin
        buf_q <= '{pc: req_addr_q, instr: bus.imem_rsp_data_i, err: bus.imem_rsp_err_i};
      end else if (state_q == ST_HOLD && state_d == ST_REQ) begin
        buf_q <= '0;
      end
    end
  end

  assign bus.imem_req_valid_o = (state_q == ST_REQ);
  assign bus.imem_req_addr_o  = req_addr_q;
  assign bus.if_valid_o       = (state_q == ST_HOLD);
  assign bus.if_pc_o          = buf_q.pc;
  assign bus.if_instr_o       = buf_q.instr;
  assign bus.if_err_o         = buf_q.err;
  assign flush_o              = redirect;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the program counter.
- Issues one outstanding request at a time to instruction memory over a valid/ready handshake.
- Holds each response in a 1-entry buffer until decode accepts it.
- Arbitrates PC redirects from trap entry, mret and EX-stage branch, and discards stale in-flight fetches after a redirect.
- Sits between the instruction memory port and the IF/ID boundary of the RV32IM core.

Parameters:
BOOT_ADDR, 32'h0000_0000, first fetch address after reset

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
imem_req_valid_o  out  1  fetch request valid
imem_req_ready_i  in  1  memory accepts request
imem_req_addr_o  out  32  fetch address, word aligned
imem_rsp_valid_i  in  1  response valid (one-cycle pulse; memory cannot be back-pressured)
imem_rsp_data_i  in  32  fetched instruction
imem_rsp_err_i  in  1  bus error on fetch
if_valid_o  out  1  instruction buffer valid toward decode
if_ready_i  in  1  decode accepts instruction
if_pc_o  out  32  PC of buffered instruction
if_instr_o  out  32  buffered instruction
if_err_o  out  1  buffered fetch error
stall_i  in  1  hazard stall; blocks handshake to decode
trap_i  in  1  trap entry redirect
trap_vector_i  in  32  trap target (mtvec-derived)
mret_i  in  1  mret redirect
mepc_i  in  32  mret target
branch_taken_i  in  1  EX branch/jump redirect
branch_target_i  in  32  branch target
flush_o  out  1  redirect taken this cycle; kill younger pipeline stages

Behaviour:
- Reset (rst_ni low, async) values:
  - state=S_BOOT; pc_q=BOOT_ADDR; discard_q=0; buffer invalid.
  - imem_req_valid_o=0, imem_req_addr_o=BOOT_ADDR.
  - if_valid_o=0, if_pc_o=0, if_instr_o=0, if_err_o=0, flush_o=0.
- Redirect priority: trap_i > mret_i > branch_taken_i.
  - redirect = OR of the three. Target = winner's address with bits[1:0] forced to 0.
  - flush_o = redirect, combinational, same cycle.
  - On redirect: pc_q <= target; buffer invalidated next edge.
  - Any decode handshake in the redirect cycle is void.
- FSM states:
  - S_BOOT: one cycle, then S_REQ.
  - S_REQ: imem_req_valid_o=1, imem_req_addr_o=req_addr_q.
    - req_addr_q is loaded from pc_q on entry and is stable while valid && !ready; a redirect never changes it.
    - On ready: pc_q <= req_addr_q+4 (mod 2^32, wraps 0xFFFF_FFFC->0), then go to S_WAIT.
    - Redirect in S_REQ before or at acceptance: discard_q <= 1; pc_q <= target (redirect overrides the +4).
  - S_WAIT: waits for imem_rsp_valid_i.
    - Response with discard_q=1, or with a redirect in the same cycle: drop it, clear discard_q, go to S_REQ.
    - Otherwise: load buffer {req_addr_q, data, err}, go to S_HOLD.
    - Redirect without a response: discard_q <= 1, stay in S_WAIT.
  - S_HOLD: if_valid_o=1.
    - Transfer when if_valid_o && if_ready_i && !stall_i && !redirect: buffer cleared, go to S_REQ.
    - Redirect: buffer cleared, go to S_REQ (new target).
- Latency:
  - Response edge to if_valid_o is 1 cycle.
  - Decode accept to next imem_req_valid_o is 1 cycle.
  - Steady-state throughput is one instruction per 3 cycles with a zero-wait memory.
- Timing rules:
  - No combinational path from if_ready_i to imem_req_valid_o.
  - Buffered outputs hold their value while stall_i is high.
- if_err_o travels with its instruction. The block does not trap on it.
- Reset mid-transaction: an outstanding response after reset release is never buffered. S_BOOT ignores imem_rsp_valid_i.

Decomposition:
- Shared package core_pkg:
  - fetch_state_e (S_BOOT, S_REQ, S_WAIT, S_HOLD)
  - redirect_src_e (NONE, TRAP, MRET, BRANCH)
  - fetch_buf_t struct {pc, instr, err}
  - ILEN/XLEN=32 constants
- Sub-module pc_redirect_sel: combinational priority select producing redirect, target and redirect_src_e. It is unit-testable alone.

Test Plan:
1. Reset release, memory always ready, responses 1 cycle later with data 0x00000013:
   - Request addresses are 0x0, 0x4, 0x8.
   - if_valid_o rises 1 cycle after each response, with if_pc_o matching the request address.
2. imem_req_ready_i low for 3 cycles in S_REQ at 0x8:
   - imem_req_addr_o is held at 0x8 throughout.
   - When ready rises, the next request is 0xC.
3. branch_taken_i=1, target 0x100, while in S_WAIT for 0x10:
   - flush_o=1 for that cycle.
   - The 0x10 response is dropped (if_valid_o stays 0).
   - The next request is 0x100.
4. trap_i, mret_i and branch_taken_i all high in one cycle (targets 0x200, 0x300, 0x400):
   - The next request is 0x200.
   - Repeat with mret_i and branch_taken_i only: the next request is 0x300.
5. Buffer holds 0x4 and stall_i=1 with if_ready_i=1 for 4 cycles:
   - if_valid_o stays 1 and if_pc_o stays 0x4; no new request is issued.
   - Releasing stall_i completes the transfer and the next request is 0x8.
6. Redirect to 0xFFFF_FFFE:
   - The request goes to 0xFFFF_FFFC; the next sequential request wraps to 0x0.
   - Assert rst_ni low while in S_WAIT: outputs take reset values immediately, and a late response is ignored.
